// File: rtl/dmem_pkg.sv
// Shared op encodings, FSM states and lane helpers for the data-memory responder.
// Lanes are little-endian; byte offset selects byte, offset bit 1 selects half.
package dmem_pkg;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  boff,
                                               input logic [2:0]  op);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{boff, 3'b000} +: 8];
    h = word[{boff[1], 4'b0000} +: 16];
    case (op)
      OP_B:    r = {{24{b[7]}}, b};
      OP_H:    r = {{16{h[15]}}, h};
      OP_BU:   r = {24'd0, b};
      OP_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Only the addressed lane changes; op[1:0] gives the access size.
  function automatic logic [31:0] lane_merge(input logic [31:0] old,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  boff,
                                             input logic [2:0]  op);
    logic [31:0] r;
    r = old;
    case (op[1:0])
      2'b00:   r[{boff, 3'b000} +: 8] = wdata[7:0];
      2'b01:   r[{boff[1], 4'b0000} +: 16] = wdata[15:0];
      default: r = wdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port DEPTHx32 word RAM, one-cycle synchronous read, no reset.
// Read data reflects the word before a same-cycle write.
module dmem_ram #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: loads/stores with sub-word RMW; ack 1 edge after accept for sw/errors, 2 otherwise.
// ready is low from accept until the ack cycle; inputs are ignored while ready=0.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [2:0]  op,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata
);

  localparam int ADDR_W = $clog2(DEPTH);

  state_t            state, state_nxt;
  logic              l_we, l_err;
  logic [2:0]        l_op;
  logic [ADDR_W+1:0] l_addr;
  logic [31:0]       l_wdata;
  logic              req_err, illegal, misal;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_rdata;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr[31:ADDR_W+2];

  always_comb begin
    illegal = we ? (op > OP_W) : (op == 3'b011 || op == 3'b110 || op == 3'b111);
    misal   = (op[1:0] == 2'b01 && addr[0]) || (op[1:0] == 2'b10 && addr[1:0] != 2'b00);
    req_err = illegal || misal;
  end

  // RAM address comes straight from the request in IDLE so the read is issued on the accept edge.
  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = l_addr[ADDR_W+1:2];
    ram_wdata = l_wdata;
    case (state)
      IDLE: begin
        ready    = 1'b1;
        ram_addr = addr[ADDR_W+1:2];
        if (req) begin
          if (req_err)                 state_nxt = RESP;
          else if (we && op == OP_W)   state_nxt = WR;
          else                         state_nxt = RD;
        end
      end
      RD:   state_nxt = l_we ? WR : RESP;
      WR: begin
        ram_we    = !reset;
        ram_wdata = lane_merge(ram_rdata, l_wdata, l_addr[1:0], l_op);
        state_nxt = IDLE;
      end
      RESP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      l_we    <= 1'b0;
      l_err   <= 1'b0;
      l_op    <= OP_B;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (state == IDLE && req) begin
      l_we    <= we;
      l_err   <= req_err;
      l_op    <= op;
      l_addr  <= addr[ADDR_W+1:0];
      l_wdata <= wdata;
    end
  end

  // rdata/err only change on the edge that raises ack, so they hold between responses.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ack <= 1'b0;
      case (state)
        WR: begin
          ack   <= 1'b1;
          err   <= 1'b0;
          rdata <= '0;
        end
        RESP: begin
          ack   <= 1'b1;
          err   <= l_err;
          rdata <= l_err ? 32'd0 : lane_extract(ram_rdata, l_addr[1:0], l_op);
        end
        default: ;
      endcase
    end
  end

  dmem_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder side of the CPU data-memory interface: accepts load/store requests carrying address, width/sign op and store data, and returns sign- or zero-extended load data. Storage is word-organised, so byte and halfword stores are done as an internal read-modify-write. The block sits between the rv32 core's data port and an on-chip word RAM. A req/ready/ack handshake lets a multi-cycle core stall on it.

## Interface
- DEPTH, 1024: number of 32-bit words; must be a power of two. ADDR_W = log2(DEPTH).
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- req  in  1  request valid; sampled only when ready=1.
- we  in  1  1 = store, 0 = load.
- addr  in  32  byte address; bits [ADDR_W+1:2] index the word, and higher bits are ignored (wrap modulo DEPTH*4).
- op  in  3  load encodings: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Store encodings: 000 sb, 001 sh, 010 sw.
- wdata  in  32  store data; byte/half taken from low bits.
- ready  out  1  1 when idle and able to accept req.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack; 1 = request rejected, no memory change.
- rdata  out  32  load result, valid with ack; 0 on stores and errors.

## Operation
- States: IDLE, RD, WR, RESP.
- IDLE: ready=1. On req, latch we/addr/op/wdata, then take the first matching branch:
  - Error: illegal op, or misaligned access → go to RESP with err set, no RAM access. Illegal op is any of 011/110/111 for loads, or any op other than 000/001/010 for stores. Misaligned is a halfword with addr[0]=1 or a word with addr[1:0]≠0.
  - sw → WR.
  - Load or sb/sh → RD; RAM read of the word is issued.
- RD: RAM word available at the end of the state.
  - Load → RESP.
  - sb/sh → WR, with the merged word formed from the old word plus the wdata lane.
- WR: RAM written (full word for sw, merged word for sb/sh). Register ack=1, err=0 → IDLE.
- RESP: register ack=1, plus either rdata = extracted lane extended per op or err → IDLE.
- Lane select is little-endian:
  - byte = word[8*addr[1:0] +: 8]
  - half = word[16*addr[1] +: 16]
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Merge: only the addressed byte/half lane is replaced; other lanes keep their old value.
- req, we, addr, op and wdata are ignored while ready=0.

## Timing
- Reset values: state IDLE, ready=1, ack=0, err=0, rdata=0. RAM contents are not cleared.
- Request accepted at edge N (req=1, ready=1). ack is high for exactly one cycle:
  - after edge N+1 for sw and for errors;
  - after edge N+2 for loads and sb/sh.
- ready=0 from edge N until the edge that raises ack. ready=1 during the ack cycle, so a req held high is accepted at the following edge (back-to-back allowed).
- rdata/err are held from the ack cycle until the next ack or reset; they are only meaningful while ack=1.
- RAM read is synchronous, one cycle of latency. A write happens on the edge that leaves WR.
- Reset has priority at every edge. Reset asserted in RD or WR abandons the access: no RAM write, no ack, state IDLE on the next cycle.
- A load from the word just written sees the new data, since the write completes before IDLE.

## Structure
- Package dmem_pkg holds:
  - op encodings (OP_B, OP_H, OP_W, OP_BU, OP_HU);
  - state enum;
  - lane-extract and lane-merge functions.
- Sub-module dmem_ram: single-port word RAM, DEPTH×32, with synchronous read, write enable, and no reset.
- FSM, request latches and output registers live in dmem_responder.

## Test plan
- sw 0x12345678 @0x10 → ack after 1 edge, err=0. Then lb @0x11 → rdata 0x00000056, and lbu @0x13 → 0x00000012, each ack after 2 edges.
- After that, sb wdata=0x000000AB @0x12 then lw @0x10 → 0x12AB5678.
- sh 0x8000 @0x16 then lh @0x16 → 0xFFFF8000, and lhu @0x16 → 0x00008000. lw @0x14 shows the upper half = 0x8000 with the lower half unchanged.
- Misaligned cases each give ack after 1 edge with err=1 and rdata=0; a following lw @0x10 is unchanged:
  - lh @0x11;
  - sw @0x12;
  - load op=011.
- Reset asserted in the RD cycle of sb 0xFF @0x10 → no ack, ready=1 next cycle. lw @0x10 still returns the old word.
- DEPTH=1024: sw 0xCAFEF00D @0x1000 then lw @0x0 → 0xCAFEF00D (wrap). Holding req high across 3 back-to-back loads gives 3 ack pulses, 3 cycles apart.
